// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 pins, validates
// 11-bit frames and turns the scan-code stream into a held make/break keycode.
module ps2_keycode_rx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  output logic [15:0] o_keycode,
  output logic        o_key_strobe,
  output logic        o_frame_err,
  output logic [7:0]  o_err_count
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (CLK_FREQ_HZ <= 0 || FILTER_LEN < 2 || FILTER_LEN > 31 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ps2_keycode_rx: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_fclk;
  logic [FW-1:0] r_fcnt;
  state_t        r_state, w_next;
  logic [3:0]    r_bitcnt;
  logic [10:0]   r_shift;
  logic [TW-1:0] r_to;
  logic          r_break;
  logic [15:0]   r_keycode;
  logic          r_strobe, r_err;
  logic [7:0]    r_errcnt;

  logic          w_differ, w_fire, w_fall;
  logic          w_err_req, w_byte_ok, w_prefix;
  logic [7:0]    w_byte;

  // fclk only follows the pin after FILTER_LEN consecutive disagreeing samples
  assign w_differ = (r_clk_s2 != r_fclk);
  assign w_fire   = w_differ && (r_fcnt == FW'(FILTER_LEN - 1));
  assign w_fall   = w_fire && !r_clk_s2;
  assign w_byte   = r_shift[8:1];
  assign w_prefix = (w_byte == 8'hF0) || (w_byte == 8'hE0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_fclk   <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (!w_differ) begin
        r_fcnt <= '0;
      end else if (w_fire) begin
        r_fclk <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_req = 1'b0;
    w_byte_ok = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          if (!r_dat_s2) w_next    = RECV;
          else           w_err_req = 1'b1;
        end
      end
      RECV: begin
        if (w_fall && r_bitcnt == 4'd10) begin
          w_next = CHECK;
        end else if (!w_fall && r_to == TW'(TIMEOUT_CYCLES - 1)) begin
          w_err_req = 1'b1;
          w_next    = IDLE;
        end
      end
      CHECK: begin
        w_next = IDLE;
        // odd parity over data+parity, stop bit high
        if ((^r_shift[9:1]) && r_shift[10]) w_byte_ok = 1'b1;
        else                                w_err_req = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_to     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != RECV || w_fall || w_err_req) r_to <= '0;
      else                                        r_to <= r_to + 1'b1;
      case (r_state)
        IDLE: if (w_fall && !r_dat_s2) begin
          r_shift  <= '0;
          r_bitcnt <= 4'd1;
        end
        RECV: begin
          if (w_fall) begin
            r_shift[r_bitcnt] <= r_dat_s2;
            r_bitcnt <= (r_bitcnt == 4'd10) ? 4'd0 : r_bitcnt + 4'd1;
          end else if (w_err_req) begin
            r_bitcnt <= '0;
          end
        end
        default: r_bitcnt <= '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_keycode <= '0;
      r_break   <= 1'b0;
      r_strobe  <= 1'b0;
      r_err     <= 1'b0;
      r_errcnt  <= '0;
    end else begin
      r_strobe <= w_byte_ok && !w_prefix;
      r_err    <= w_err_req;
      if (w_err_req && r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
      if (w_byte_ok) begin
        if (w_byte == 8'hF0) begin
          r_break <= 1'b1;
        end else if (w_byte != 8'hE0) begin
          r_keycode <= {(r_break ? 8'hF0 : 8'h00), w_byte};
          r_break   <= 1'b0;
        end
      end
    end
  end

  assign o_keycode    = r_keycode;
  assign o_key_strobe = r_strobe;
  assign o_frame_err  = r_err;
  assign o_err_count  = r_errcnt;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Randomized bench for ps2_keycode_rx: drives PS/2 frames on the pins and
// compares outputs with a byte-level make/break/error model.
module tb_ps2_keycode_rx;
  localparam int FL = 4;
  localparam int TO = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2c = 1'b1;
  logic        ps2d = 1'b1;
  logic [15:0] keycode;
  logic        key_strobe, frame_err;
  logic [7:0]  err_count;

  ps2_keycode_rx #(.CLK_FREQ_HZ(100_000_000), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_ps2_clk(ps2c), .i_ps2_data(ps2d),
    .o_keycode(keycode), .o_key_strobe(key_strobe), .o_frame_err(frame_err),
    .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // observed pulse activity
  int n_strobe = 0, n_err = 0, viol = 0, t_strobe = 0, t_err = 0, t_stop = 0;
  logic [15:0] strobe_key = '0;
  bit prev_s = 0, prev_e = 0;
  always @(negedge clk) begin
    if (key_strobe) begin n_strobe++; strobe_key = keycode; t_strobe = cyc; end
    if (frame_err) begin n_err++; t_err = cyc; end
    if (key_strobe && frame_err) viol++;
    if ((key_strobe && prev_s) || (frame_err && prev_e)) viol++;
    prev_s = key_strobe;
    prev_e = frame_err;
  end

  // reference model at scan-code level
  int          m_strobes = 0, m_errs = 0, m_errcnt = 0;
  logic [15:0] m_key = '0;
  bit          m_bp = 0;

  task automatic model_err();
    m_errs++;
    if (m_errcnt < 255) m_errcnt++;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) model_err();
    else if (b == 8'hF0) m_bp = 1;
    else if (b != 8'hE0) begin
      m_key = m_bp ? {8'hF0, b} : {8'h00, b};
      m_bp = 0;
      m_strobes++;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // glitch_bit < 0: no glitch; nbits < 11: truncated frame (not modelled here)
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] f;
    int half;
    half = $urandom_range(12, 25);
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      wait_cyc(half);
      ps2c = 1'b0;
      if (i == 10) t_stop = cyc;
      wait_cyc(half);
      ps2c = 1'b1;
      if (i == glitch_bit) begin
        wait_cyc(8);
        ps2c = 1'b0;
        wait_cyc(FL - 1);
        ps2c = 1'b1;
      end
      wait_cyc(half);
    end
    ps2d = 1'b1;
    if (nbits == 11) model_frame(b, !bad_par && !bad_stop);
    wait_cyc(FL + 20);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++; if (keycode !== 16'h0000) begin failures++; $display("FAIL reset_key got=%h exp=0000", keycode); end
    checks++; if (key_strobe !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", key_strobe, frame_err); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL reset_errcnt got=%h exp=00", err_count); end
    rst_n = 1'b1;
    wait_cyc(FL + 10);
    checks++; if (n_strobe != 0 || n_err != 0) begin failures++; $display("FAIL reset_idle got=%0d/%0d exp=0/0", n_strobe, n_err); end
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 0, 0, 11, -1);
    checks++; if (keycode !== 16'h001C) begin failures++; $display("FAIL basic_key got=%h exp=001C", keycode); end
    checks++; if (n_strobe != m_strobes) begin failures++; $display("FAIL basic_strobes got=%0d exp=%0d", n_strobe, m_strobes); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL basic_errcnt got=%h exp=00", err_count); end
    checks++; if (t_strobe - t_stop < FL + 2 || t_strobe - t_stop > FL + 5) begin
      failures++; $display("FAIL basic_latency got=%0d exp=%0d..%0d", t_strobe - t_stop, FL + 2, FL + 5); end
  endtask

  task automatic test_break();
    int s0;
    s0 = n_strobe;
    send_frame(8'hF0, 0, 0, 11, -1);
    checks++; if (n_strobe != s0 || keycode !== 16'h001C) begin failures++; $display("FAIL break_prefix got=%0d/%h exp=%0d/001C", n_strobe, keycode, s0); end
    send_frame(8'h1C, 0, 0, 11, -1);
    checks++; if (keycode !== 16'hF01C || n_strobe != s0 + 1) begin failures++; $display("FAIL break_key got=%h/%0d exp=F01C/%0d", keycode, n_strobe, s0 + 1); end
  endtask

  task automatic test_extended();
    int s0;
    s0 = n_strobe;
    send_frame(8'hE0, 0, 0, 11, -1);
    send_frame(8'hF0, 0, 0, 11, -1);
    send_frame(8'h4B, 0, 0, 11, -1);
    checks++; if (keycode !== 16'hF04B || n_strobe != s0 + 1) begin failures++; $display("FAIL ext_break got=%h/%0d exp=F04B/%0d", keycode, n_strobe, s0 + 1); end
    checks++; if (strobe_key !== 16'hF04B) begin failures++; $display("FAIL ext_strobe_key got=%h exp=F04B", strobe_key); end
    send_frame(8'h29, 0, 0, 11, -1);
    checks++; if (keycode !== 16'h0029) begin failures++; $display("FAIL ext_make got=%h exp=0029", keycode); end
  endtask

  task automatic test_parity();
    int s0;
    s0 = n_strobe;
    send_frame(8'h1B, 1, 0, 11, -1);
    checks++; if (n_err != m_errs || err_count !== 8'd1) begin failures++; $display("FAIL parity_err got=%0d/%0d exp=%0d/1", n_err, err_count, m_errs); end
    checks++; if (keycode !== 16'h0029 || n_strobe != s0) begin failures++; $display("FAIL parity_key got=%h exp=0029", keycode); end
    checks++; if (t_err - t_stop < FL + 2 || t_err - t_stop > FL + 5) begin
      failures++; $display("FAIL parity_latency got=%0d exp=%0d..%0d", t_err - t_stop, FL + 2, FL + 5); end
    send_frame(8'h1B, 0, 0, 11, -1);
    checks++; if (keycode !== 16'h001B) begin failures++; $display("FAIL parity_recover got=%h exp=001B", keycode); end
    send_frame(8'h33, 0, 1, 11, -1);
    checks++; if (n_err != m_errs || keycode !== 16'h001B) begin failures++; $display("FAIL stop_err got=%0d/%h exp=%0d/001B", n_err, keycode, m_errs); end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_err;
    send_frame(8'h55, 0, 0, 5, -1);
    wait_cyc(TO + 100);
    model_err();
    checks++; if (n_err != e0 + 1 || err_count !== 8'(m_errcnt)) begin failures++; $display("FAIL timeout_err got=%0d/%0d exp=%0d/%0d", n_err, err_count, e0 + 1, m_errcnt); end
    send_frame(8'h42, 0, 0, 11, -1);
    checks++; if (keycode !== 16'h0042 || n_err != e0 + 1) begin failures++; $display("FAIL timeout_recover got=%h exp=0042", keycode); end
  endtask

  task automatic test_glitch();
    send_frame(8'h5A, 0, 0, 11, 3);
    send_frame(8'h6B, 0, 0, 11, 8);
    checks++; if (keycode !== 16'h006B || n_err != m_errs || n_strobe != m_strobes) begin
      failures++; $display("FAIL glitch got=%h/%0d/%0d exp=006B/%0d/%0d", keycode, n_err, n_strobe, m_errs, m_strobes); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r, bp, bs, gl;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 7);
      b = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 15) == 0);
      gl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
      send_frame(b, bit'(bp), bit'(bs), 11, gl);
      checks++; if (keycode !== m_key || n_strobe != m_strobes || n_err != m_errs || err_count !== 8'(m_errcnt)) begin
        failures++; $display("FAIL random[%0d] b=%h got=%h/%0d/%0d/%0d exp=%h/%0d/%0d/%0d", k, b,
          keycode, n_strobe, n_err, err_count, m_key, m_strobes, m_errs, m_errcnt); end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] f;
    send_frame(8'hF0, 0, 0, 11, -1);
    f = {1'b1, ~^8'h77, 8'h77, 1'b0};
    for (int i = 0; i < 7; i++) begin
      ps2d = f[i];
      wait_cyc(15);
      ps2c = 1'b0;
      wait_cyc(15);
      if (i < 6) ps2c = 1'b1;
      if (i < 6) wait_cyc(15);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (keycode !== 16'h0000 || err_count !== 8'h00 || key_strobe !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_mid got=%h/%h/%b/%b exp=0000/00/0/0", keycode, err_count, key_strobe, frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    m_key = '0; m_bp = 0; m_errcnt = 0;
    wait_cyc(TO + 50);
    send_frame(8'h1C, 0, 0, 11, -1);
    checks++; if (keycode !== 16'h001C || n_err != m_errs) begin failures++; $display("FAIL reset_mid_after got=%h/%0d exp=001C/%0d", keycode, n_err, m_errs); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 260; k++) begin
      ps2d = 1'b1;
      wait_cyc(4);
      ps2c = 1'b0;
      wait_cyc(12);
      ps2c = 1'b1;
      wait_cyc(12);
      model_err();
    end
    wait_cyc(20);
    checks++; if (err_count !== 8'hFF || n_err != m_errs) begin failures++; $display("FAIL saturate got=%h/%0d exp=FF/%0d", err_count, n_err, m_errs); end
    checks++; if (keycode !== 16'h001C) begin failures++; $display("FAIL saturate_key got=%h exp=001C", keycode); end
  endtask

  task automatic test_pulses();
    checks++; if (viol != 0) begin failures++; $display("FAIL pulse_rules got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_extended();
    test_parity();
    test_timeout();
    test_glitch();
    test_random();
    test_reset_mid();
    test_saturation();
    test_pulses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
